// File: rtl/spi_loader_pkg.sv
// Shared constants, FSM state type and counter helper for the SPI memory loader.
package spi_loader_pkg;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam int         FRAME_BITS = 72;

  localparam logic [6:0] CMD_END   = 7'd8;
  localparam logic [6:0] ADDR_END  = 7'd40;
  localparam logic [6:0] FRAME_END = 7'(FRAME_BITS);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE, SKIP} loader_state_e;

  // Bit counter advance that can never pass the end of a frame.
  function automatic logic [6:0] sat_add(input logic [6:0] cnt, input logic [6:0] step);
    logic [7:0] sum;
    sum = {1'b0, cnt} + {1'b0, step};
    if (sum > {1'b0, FRAME_END}) begin
      sat_add = FRAME_END;
    end else begin
      sat_add = sum[6:0];
    end
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronises sclk/cs/sdi into the system clock domain and detects sclk rise and cs edges.
// The sdi lanes get the same delay as sclk, so they are valid on the detected rise cycle.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs,
  input  logic [3:0] sdi,
  output logic       sclk_rise,
  output logic       cs_rise,
  output logic       cs_fall,
  output logic [3:0] sdi_sync
);

  logic [SYNC_STAGES-1:0]      sclk_pipe;
  logic [SYNC_STAGES-1:0]      cs_pipe;
  logic [SYNC_STAGES-1:0][3:0] sdi_pipe;
  logic                        sclk_prev;
  logic                        cs_prev;

  // Synchroniser chains plus one history flop for edge detection; cs idles deasserted (high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_pipe <= '0;
      cs_pipe   <= '1;
      sdi_pipe  <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
      cs_pipe   <= {cs_pipe[SYNC_STAGES-2:0], cs};
      sdi_pipe  <= {sdi_pipe[SYNC_STAGES-2:0], sdi};
      sclk_prev <= sclk_pipe[SYNC_STAGES-1];
      cs_prev   <= cs_pipe[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_pipe[SYNC_STAGES-1] & ~sclk_prev;
  assign cs_rise   = cs_pipe[SYNC_STAGES-1] & ~cs_prev;
  assign cs_fall   = ~cs_pipe[SYNC_STAGES-1] & cs_prev;
  assign sdi_sync  = sdi_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_loader.sv
// SPI slave turning cmd+addr+data load frames into single 32-bit req/gnt memory writes.
// Optional SPI_QUAD_EN adds the 4-lane write command (addr/data one nibble per sclk edge).
module spi_mem_loader
  import spi_loader_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              spi_sclk,
  input  logic              spi_cs,
  input  logic              spi_sdi0,
  input  logic              spi_sdi1,
  input  logic              spi_sdi2,
  input  logic              spi_sdi3,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_be_o,
  output logic              busy_o,
  output logic              frame_err_o,
  output logic              overrun_o
);

  logic          sclk_rise;
  logic          cs_rise;
  logic          cs_fall;
  logic [3:0]    sdi_sync;

  loader_state_e state;
  logic [6:0]    bit_cnt;
  logic [63:0]   shreg;
  logic          quad;

  logic [6:0]    step;
  logic [6:0]    cnt_next;
  logic [63:0]   shift_next;
  logic [7:0]    cmd_next;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk_i),
    .rst       (rst_i),
    .sclk      (spi_sclk),
    .cs        (spi_cs),
    .sdi       ({spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0}),
    .sclk_rise (sclk_rise),
    .cs_rise   (cs_rise),
    .cs_fall   (cs_fall),
    .sdi_sync  (sdi_sync)
  );

  // Next shift-register / counter values for the current lane width.
  always_comb begin
    step       = 7'd1;
    shift_next = {shreg[62:0], sdi_sync[0]};
    if (quad) begin
      step       = 7'd4;
      shift_next = {shreg[59:0], sdi_sync};
    end else begin
      step       = 7'd1;
      shift_next = {shreg[62:0], sdi_sync[0]};
    end
    cnt_next = sat_add(bit_cnt, step);
    cmd_next = {shreg[6:0], sdi_sync[0]};
  end

  // Frame FSM, shift register, bit counter and the pending write register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bit_cnt     <= 7'd0;
      shreg       <= 64'd0;
      quad        <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= 32'd0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (mem_req_o && mem_gnt_i) begin
        mem_req_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= CMD;
            bit_cnt <= 7'd0;
            quad    <= 1'b0;
          end
        end
        CMD, ADDR, DATA: begin
          if (cs_rise) begin
            state       <= IDLE;
            frame_err_o <= (bit_cnt != 7'd0);
          end else if (sclk_rise) begin
            shreg   <= shift_next;
            bit_cnt <= cnt_next;
            if (state == CMD && cnt_next == CMD_END) begin
              if (cmd_next == CMD_WRITE) begin
                state <= ADDR;
`ifdef SPI_QUAD_EN
              end else if (cmd_next == CMD_QWRITE) begin
                state <= ADDR;
                quad  <= 1'b1;
`endif
              end else begin
                state <= SKIP;
              end
            end else if (state == ADDR && cnt_next == ADDR_END) begin
              state <= DATA;
            end else if (state == DATA && cnt_next == FRAME_END) begin
              state <= DONE;
              // A grant retiring the old write this cycle frees the slot for back-to-back commits.
              if (!mem_req_o || mem_gnt_i) begin
                mem_req_o   <= 1'b1;
                mem_addr_o  <= shift_next[32 +: ADDR_W];
                mem_wdata_o <= shift_next[31:0];
              end else begin
                overrun_o <= 1'b1;
              end
            end
          end
        end
        DONE, SKIP: begin
          if (cs_rise) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_we_o = mem_req_o;
  assign mem_be_o = {4{mem_req_o}};
  assign busy_o   = (state != IDLE) | mem_req_o;

endmodule

// File: tb/tb_spi_mem_loader.sv
// Self-checking bench for spi_mem_loader: directed table, corner sequences and random frames
// checked against a frame-level reference model.
module tb_spi_mem_loader;

`ifdef SPI_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sdi0 = 1'b0, spi_sdi1 = 1'b0, spi_sdi2 = 1'b0, spi_sdi3 = 1'b0;
  logic        mem_gnt = 1'b1;
  logic        mem_req_o, mem_we_o, busy_o, frame_err_o, overrun_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;

  always #5 clk = ~clk;

  spi_mem_loader dut (
    .clk_i(clk), .rst_i(rst), .spi_sclk(spi_sclk), .spi_cs(spi_cs),
    .spi_sdi0(spi_sdi0), .spi_sdi1(spi_sdi1), .spi_sdi2(spi_sdi2), .spi_sdi3(spi_sdi3),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .busy_o(busy_o), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [7:0] cmd; logic [31:0] addr; logic [31:0] data; int edges; int exp_wr; int exp_err; } vec_t;

  int  vectors = 0, miscompares = 0;
  wr_t got_q[$], exp_q[$];
  int  err_cnt = 0, ovr_cnt = 0, wr_cnt = 0, req_cycles = 0;
  int  exp_err = 0, exp_ovr = 0;
  logic gnt_val = 1'b1;
  bit   rand_gnt = 1'b0;
  logic prev_req = 1'b0, prev_gnt = 1'b0;
  logic [31:0] prev_addr = 32'd0, prev_data = 32'd0;

  // Grant source: fixed level or a coin toss each cycle.
  always @(posedge clk) begin
    #1;
    mem_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : gnt_val;
  end

  // Bus monitor: collects completed writes, counts pulses, checks the hold rule.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_req && !prev_gnt) begin
        vectors++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== prev_addr || mem_wdata_o !== prev_data) begin
          miscompares++;
          $display("FAIL hold: req=%b addr=%h data=%h, required 1 %h %h", mem_req_o, mem_addr_o, mem_wdata_o, prev_addr, prev_data);
        end
      end
      if (mem_req_o && mem_gnt) begin
        got_q.push_back('{mem_addr_o, mem_wdata_o});
        wr_cnt++;
        vectors++;
        if (mem_we_o !== 1'b1 || mem_be_o !== 4'hF) begin
          miscompares++;
          $display("FAIL we_be: we=%b be=%h, required 1 f", mem_we_o, mem_be_o);
        end
      end
      if (mem_req_o) req_cycles++;
      if (frame_err_o) err_cnt++;
      if (overrun_o) ovr_cnt++;
    end
    prev_req  = rst ? 1'b0 : mem_req_o;
    prev_gnt  = mem_gnt;
    prev_addr = mem_addr_o;
    prev_data = mem_wdata_o;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference outcome of a frame: 0 nothing, 1 frame error, 2 write.
  function automatic int predict(input logic [7:0] cmd, input int edges);
    if (edges == 0) return 0;
    if (edges < 8) return 1;
    if (cmd == 8'h02) return (edges >= 72) ? 2 : 1;
    if (cmd == 8'h38 && QUAD) return (edges >= 24) ? 2 : 1;
    return 0;
  endfunction

  task automatic put_data(input logic [7:0] cmd, input logic [63:0] ad, input int k, input bit quad);
    logic [3:0] nib;
    if (k < 8) nib = {3'b000, cmd[7-k]};
    else if (quad) nib = (k - 8 < 16) ? ad[63-4*(k-8) -: 4] : 4'h0;
    else nib = (k - 8 < 64) ? {3'b000, ad[63-(k-8)]} : 4'h0;
    {spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0} = nib;
  endtask

  task automatic spi_edges(input logic [7:0] cmd, input logic [63:0] ad, input int n, input bit quad);
    for (int k = 0; k < n; k++) begin
      put_data(cmd, ad, k, quad);
      tick(3);
      spi_sclk = 1'b1;
      tick(3);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d, input int edges, input bit drop);
    bit quad;
    int k;
    quad = (cmd == 8'h38) && QUAD;
    k = predict(cmd, edges);
    if (k == 1) exp_err++;
    else if (k == 2) begin
      if (drop) exp_ovr++;
      else exp_q.push_back('{a, d});
    end
    spi_cs = 1'b0;
    tick(3);
    spi_edges(cmd, {a, d}, edges, quad);
    {spi_sdi3, spi_sdi2, spi_sdi1, spi_sdi0} = 4'h0;
    tick(3);
    spi_cs = 1'b1;
    tick(12);
  endtask

  task automatic settle(input string name);
    tick(30);
    chk({name, " nwrites"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      wr_t g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk({name, " addr"}, g.addr, e.addr);
      chk({name, " data"}, g.data, e.data);
    end
    got_q.delete();
    exp_q.delete();
    chk({name, " frame_err"}, err_cnt, exp_err);
    chk({name, " overrun"}, ovr_cnt, exp_ovr);
  endtask

  vec_t tbl[12];
  logic [31:0] fib[32];

  initial begin
    tbl[0]  = '{8'h02, 32'h80,  32'h00000FFF, 72, 1, 0};
    tbl[1]  = '{8'h02, 32'h100, 32'hDEADBEEF, 20, 0, 1};
    tbl[2]  = '{8'h02, 32'h104, 32'h12345678, 72, 1, 0};
    tbl[3]  = '{8'h05, 32'h200, 32'hAAAAAAAA, 72, 0, 0};
    tbl[4]  = '{8'h02, 32'h84,  32'h55AA55AA, 72, 1, 0};
    tbl[5]  = '{8'h02, 32'h88,  32'h00000001, 0,  0, 0};
    tbl[6]  = '{8'h02, 32'h88,  32'h00000001, 5,  0, 1};
    tbl[7]  = '{8'h05, 32'h0,   32'h0,        3,  0, 1};
    tbl[8]  = '{8'h02, 32'h8B,  32'hCAFEF00D, 80, 1, 0};
    tbl[9]  = '{8'h02, 32'h90,  32'h00000001, 71, 0, 1};
    tbl[10] = '{8'h38, 32'h300, 32'h87654321, QUAD ? 24 : 72, QUAD ? 1 : 0, 0};
    tbl[11] = '{8'h38, 32'h304, 32'h0BADCAFE, QUAD ? 23 : 30, 0, QUAD ? 1 : 0};
    fib[0] = 32'd0;
    fib[1] = 32'd1;
    for (int i = 2; i < 32; i++) fib[i] = fib[i-1] + fib[i-2];

    // Reset state
    tick(4);
    chk("reset ctrl", {mem_req_o, mem_we_o, mem_be_o, busy_o, frame_err_o, overrun_o}, 64'd0);
    chk("reset addr", mem_addr_o, 64'd0);
    chk("reset data", mem_wdata_o, 64'd0);
    rst = 1'b0;
    tick(6);
    chk("idle busy", busy_o, 64'd0);

    // Single write with gnt tied high: req for exactly one cycle
    req_cycles = 0;
    frame(8'h02, 32'h80, 32'h00000FFF, 72, 1'b0);
    settle("t1");
    chk("t1 req cycles", req_cycles, 64'd1);

    // Grant delayed five cycles: req held six cycles
    gnt_val = 1'b0;
    tick(2);
    req_cycles = 0;
    exp_q.push_back('{32'h80, 32'h00000FFF});
    spi_cs = 1'b0;
    tick(3);
    spi_edges(8'h02, {32'h80, 32'h00000FFF}, 71, 1'b0);
    put_data(8'h02, {32'h80, 32'h00000FFF}, 71, 1'b0);
    tick(3);
    spi_sclk = 1'b1;
    begin
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (mem_req_o !== 1'b1 && n < 200);
      chk("t2 req rise in time", n < 200, 64'd1);
    end
    repeat (4) @(negedge clk);
    gnt_val = 1'b1;
    tick(3);
    spi_sclk = 1'b0;
    tick(3);
    spi_cs = 1'b1;
    tick(12);
    settle("t2");
    chk("t2 req cycles", req_cycles, 64'd6);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      int w0, e0;
      w0 = wr_cnt;
      e0 = err_cnt;
      frame(tbl[i].cmd, tbl[i].addr, tbl[i].data, tbl[i].edges, 1'b0);
      settle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d writes", i), wr_cnt - w0, tbl[i].exp_wr);
      chk($sformatf("vec%0d errs", i), err_cnt - e0, tbl[i].exp_err);
    end

    // Overrun: second frame completes while the first is still pending
    gnt_val = 1'b0;
    tick(2);
    frame(8'h02, 32'h80, 32'h11, 72, 1'b0);
    frame(8'h02, 32'h84, 32'h22, 72, 1'b1);
    chk("t5 overrun", ovr_cnt, exp_ovr);
    chk("t5 no write yet", got_q.size(), 64'd0);
    chk("t5 req held", mem_req_o, 64'd1);
    gnt_val = 1'b1;
    settle("t5");

    // Program image load
    for (int i = 0; i < 32; i++) frame(8'h02, 32'h80 + 32'(4 * i), fib[i], 72, 1'b0);
    settle("fib");
`ifdef SPI_QUAD_EN
    for (int i = 0; i < 32; i++) frame(8'h38, 32'h80 + 32'(4 * i), fib[i], 24, 1'b0);
    settle("fib quad");
`endif

    // Reset with a request outstanding, then mid-frame
    gnt_val = 1'b0;
    tick(2);
    frame(8'h02, 32'hA0, 32'h77, 72, 1'b0);
    chk("rst pre req", mem_req_o, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst req", mem_req_o, 64'd0);
    chk("rst busy", busy_o, 64'd0);
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(4);
    spi_cs = 1'b0;
    tick(3);
    spi_edges(8'h02, {32'hB0, 32'h99}, 10, 1'b0);
    chk("midframe busy", busy_o, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midframe rst busy", busy_o, 64'd0);
    spi_cs = 1'b1;
    tick(5);
    rst = 1'b0;
    gnt_val = 1'b1;
    tick(10);
    frame(8'h02, 32'hC0, 32'h5A5A0001, 72, 1'b0);
    settle("post rst");

    // Random frames, random grant
    rand_gnt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      logic [7:0] cmd;
      int sel, full, edges;
      sel = $urandom_range(0, 4);
      case (sel)
        0, 1: cmd = 8'h02;
        2: cmd = 8'h38;
        3: cmd = 8'h05;
        default: cmd = 8'($urandom);
      endcase
      full = (cmd == 8'h38 && QUAD) ? 24 : 72;
      sel = $urandom_range(0, 9);
      if (sel < 7) edges = full;
      else if (sel == 7) edges = 0;
      else edges = $urandom_range(1, full - 1);
      frame(cmd, $urandom, $urandom, edges, 1'b0);
      settle($sformatf("rnd%0d", i));
    end
    rand_gnt = 1'b0;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
